// File: rtl/de10_gpio_bank.sv
// de10_gpio_bank: memory-mapped LED/GPIO bank for the DE10 board.
// Word-addressed register file (addr[21:0]) driving LEDR and a bidirectional GPIO bank
// with per-pin direction, a synchronised input path and registered read data.
// Optional feature macro: GPIO_IRQ_EN. When defined, edge-triggered interrupt logic is
// compiled in: edge detector, arming counter, IRQ_EN, EDGE_SEL and IRQ_STAT.

module de10_gpio_bank #(
  parameter int unsigned GPIO_W      = 32,
  parameter int unsigned LED_W       = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       addr,
  input  logic              wr,
  input  logic [31:0]       idata,
  output logic [31:0]       odata,
  output logic              irq,
  output logic [LED_W-1:0]  LEDR,
  inout  wire  [GPIO_W-1:0] GPIO
);

  // Register map (word addresses, addr[21:0])
  localparam logic [21:0] AddrLed     = 22'd0;
  localparam logic [21:0] AddrOut     = 22'd1;
  localparam logic [21:0] AddrDir     = 22'd2;
  localparam logic [21:0] AddrIn      = 22'd3;
  localparam logic [21:0] AddrIrqEn   = 22'd4;
  localparam logic [21:0] AddrEdgeSel = 22'd5;
  localparam logic [21:0] AddrIrqStat = 22'd6;
  localparam logic [21:0] AddrOutSet  = 22'd7;
  localparam logic [21:0] AddrOutClr  = 22'd8;

  logic [21:0]       reg_addr;
  logic [GPIO_W-1:0] wdata_gpio;
  logic [LED_W-1:0]  wdata_led;

  assign reg_addr   = addr[21:0];
  assign wdata_gpio = idata[GPIO_W-1:0];
  assign wdata_led  = idata[LED_W-1:0];

  // Upper address bits are not decoded; the sink keeps lint quiet for narrow widths.
  logic unused_bits;
  assign unused_bits = ^{addr[31:22], idata};

  // ---------------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------------
  logic we_led, we_out, we_dir, we_set, we_clr;

  assign we_led = wr && (reg_addr == AddrLed);
  assign we_out = wr && (reg_addr == AddrOut);
  assign we_dir = wr && (reg_addr == AddrDir);
  assign we_set = wr && (reg_addr == AddrOutSet);
  assign we_clr = wr && (reg_addr == AddrOutClr);

  // ---------------------------------------------------------------------------
  // Output-side registers
  // ---------------------------------------------------------------------------
  logic [LED_W-1:0]  led_q;
  logic [GPIO_W-1:0] out_q, out_d;
  logic [GPIO_W-1:0] dir_q;

  // OUT next state: full write, or bitwise set/clear of the bits written as 1.
  always_comb begin
    out_d = out_q;
    if (we_out) begin
      out_d = wdata_gpio;
    end else if (we_set) begin
      out_d = out_q | wdata_gpio;
    end else if (we_clr) begin
      out_d = out_q & ~wdata_gpio;
    end
  end

  // LED, OUT and DIR register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= '0;
      out_q <= '0;
      dir_q <= '0;
    end else begin
      if (we_led) led_q <= wdata_led;
      if (we_dir) dir_q <= wdata_gpio;
      out_q <= out_d;
    end
  end

  assign LEDR = led_q;

  // Per-pin tristate: drive OUT only where DIR selects output.
  for (genvar g = 0; g < GPIO_W; g++) begin : g_pin
    assign GPIO[g] = dir_q[g] ? out_q[g] : 1'bz;
  end

  // ---------------------------------------------------------------------------
  // Input synchroniser; samples the pad, so driven outputs read back too.
  // ---------------------------------------------------------------------------
  logic [GPIO_W-1:0] sync_q [SYNC_STAGES];
  logic [GPIO_W-1:0] pin_in;

  // SYNC_STAGES-deep flop chain per pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= GPIO;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign pin_in = sync_q[SYNC_STAGES-1];

`ifdef GPIO_IRQ_EN
  // ---------------------------------------------------------------------------
  // Edge-triggered interrupt logic
  // ---------------------------------------------------------------------------
  typedef enum logic {StArming, StArmed} arm_state_e;

  arm_state_e        arm_state_q;
  logic [2:0]        arm_cnt_q;
  logic [GPIO_W-1:0] irq_en_q;
  logic [GPIO_W-1:0] edge_sel_q;
  logic [GPIO_W-1:0] stat_q, stat_d;
  logic [GPIO_W-1:0] prev_q;
  logic [GPIO_W-1:0] events;
  logic [GPIO_W-1:0] clr_mask;
  logic              we_en, we_sel, we_stat;

  assign we_en   = wr && (reg_addr == AddrIrqEn);
  assign we_sel  = wr && (reg_addr == AddrEdgeSel);
  assign we_stat = wr && (reg_addr == AddrIrqStat);

  // Arming counter: hold off status updates for SYNC_STAGES+1 edges after reset so the
  // synchroniser filling from 0 cannot look like a pin edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_state_q <= StArming;
      arm_cnt_q   <= '0;
    end else begin
      case (arm_state_q)
        StArming: begin
          if (arm_cnt_q == 3'(SYNC_STAGES)) begin
            arm_state_q <= StArmed;
          end else begin
            arm_cnt_q <= arm_cnt_q + 3'd1;
          end
        end
        StArmed: begin
          arm_state_q <= StArmed;
        end
        default: begin
          arm_state_q <= StArming;
        end
      endcase
    end
  end

  // Per-pin edge event against the previous synchronised sample.
  assign events   = (edge_sel_q & pin_in & ~prev_q) | (~edge_sel_q & ~pin_in & prev_q);
  assign clr_mask = we_stat ? wdata_gpio : '0;

  // Status next state: a new event beats a same-cycle W1C of the same bit.
  always_comb begin
    stat_d = stat_q & ~clr_mask;
    if (arm_state_q == StArmed) begin
      stat_d = stat_d | events;
    end
  end

  // Interrupt configuration, status, previous sample and registered irq.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q   <= '0;
      edge_sel_q <= '0;
      stat_q     <= '0;
      prev_q     <= '0;
      irq        <= 1'b0;
    end else begin
      if (we_en)  irq_en_q   <= wdata_gpio;
      if (we_sel) edge_sel_q <= wdata_gpio;
      stat_q <= stat_d;
      prev_q <= pin_in;
      irq    <= |(stat_q & irq_en_q);
    end
  end
`else
  assign irq = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [31:0] rdata;

  // Read mux; unlisted and write-only addresses return 0.
  always_comb begin
    rdata = '0;
    case (reg_addr)
      AddrLed:     rdata = 32'(led_q);
      AddrOut:     rdata = 32'(out_q);
      AddrDir:     rdata = 32'(dir_q);
      AddrIn:      rdata = 32'(pin_in);
`ifdef GPIO_IRQ_EN
      AddrIrqEn:   rdata = 32'(irq_en_q);
      AddrEdgeSel: rdata = 32'(edge_sel_q);
      AddrIrqStat: rdata = 32'(stat_q);
`endif
      default:     rdata = '0;
    endcase
  end

  // Registered read data; a same-cycle write is seen on the following read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      odata <= '0;
    end else begin
      odata <= rdata;
    end
  end

endmodule

// File: doc/de10_gpio_bank.md
# de10_gpio_bank

Parametrised memory-mapped LED/GPIO peripheral for the DE10 board, and the successor to the fixed two-register LED/GPIO block. It decodes a word address on the core's peripheral bus and drives LEDR plus a bidirectional GPIO bank with per-pin direction control. The input path is synchronised, and optional edge-triggered interrupts are provided. Read data is registered, so it is valid one cycle after the address.

## Interface
Parameters:
- GPIO_W, 32: GPIO pin count, 1..32.
- LED_W, 10: LED count, 1..32.
- SYNC_STAGES, 2: input synchroniser depth, 2..4.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset; asynchronous, active-low.
- addr  in  32  byte-agnostic word address; only addr[21:0] is decoded.
- wr  in  1  write strobe, sampled at posedge clk.
- idata  in  32  write data.
- odata  out  32  registered read data.
- irq  out  1  level interrupt, registered.
- LEDR  out  LED_W  LED drive.
- GPIO  inout  GPIO_W  pins; bit i is driven when DIR[i]=1, otherwise high-Z.

## Operation
Register map (addr[21:0]; unlisted addresses read 0 and ignore writes; bits above the field width read 0):
- 0 LED, rw: drives LEDR.
- 1 OUT, rw: output data.
- 2 DIR, rw: 1 = output.
- 3 IN, ro: synchronised pin state, including pins that are driven as outputs.
- 4 IRQ_EN, rw.
- 5 EDGE_SEL, rw: 1 = rising, 0 = falling.
- 6 IRQ_STAT, r/W1C.
- 7 OUT_SET, wo, W1S on OUT: reads 0.
- 8 OUT_CLR, wo, W1C on OUT: reads 0.

Write behaviour:
- Registers update at the posedge where wr=1.
- OUT_SET and OUT_CLR modify only the bits written as 1.

Input path and edge detection:
- Each pin passes through a SYNC_STAGES flop chain, then a one-flop `prev` sample.
- An edge event for pin i is raised when:
  - EDGE_SEL[i]=1 and sync[i] & ~prev[i], or
  - EDGE_SEL[i]=0 and ~sync[i] & prev[i].
- An event sets IRQ_STAT[i] whether or not IRQ_EN[i] is set.
- If an event and a W1C of the same bit occur in the same cycle, set wins.

Arming counter:
- After rst_n deasserts, a counter suppresses status setting for SYNC_STAGES+1 cycles. This prevents spurious edges while the synchroniser fills.
- Counter states: ARMING (counting) then ARMED (terminal). Reset returns the counter to ARMING at 0.

Interrupt output:
- irq is registered as |(IRQ_STAT & IRQ_EN).

Reset values (asynchronous, with rst_n=0):
- All registers, synchroniser flops, prev, odata and irq are 0.
- DIR=0, so all GPIO pins are high-Z, and LEDR=0.
- Reset asserted mid-operation clears all state immediately, including pending IRQ_STAT bits.

## Timing
Read path:
- odata at posedge N+1 holds the register selected by addr at posedge N.
- A read and a write to the same address in the same cycle return the pre-write value.
- odata holds its last value until the next edge; there is no read strobe.

Write path:
- LEDR and GPIO drive/direction change in the cycle after the write edge.

Input path:
- IN reflects a pin change SYNC_STAGES edges after the change.
- IRQ_STAT updates one edge later than IN.
- irq asserts one edge after IRQ_STAT.
- A W1C of the last enabled bit drops irq one edge after the clear.

Edge cases:
- Pulses shorter than one clock may be missed; this is not required to be detected.
- Widths: writes are truncated to GPIO_W or LED_W; unused read bits are zero-extended.

## Configuration
- GPIO_IRQ_EN defined: the edge detector, arming counter, IRQ_EN, EDGE_SEL and IRQ_STAT are compiled in, and irq behaves as above.
- GPIO_IRQ_EN undefined:
  - Addresses 4–6 read 0 and ignore writes.
  - irq is tied to 0.
  - The prev flops and arming counter are absent.
  - IN, OUT, DIR, LED, OUT_SET and OUT_CLR behave identically to the defined case.

## Test plan
- Reset: hold rst_n=0 with GPIO externally pulled to 0xFFFFFFFF, then release. Required: all reads return 0 (except IN=0xFFFFFFFF after SYNC_STAGES cycles), IRQ_STAT stays 0, and irq=0.
- Output path: write DIR=0x0000FFFF, then OUT=0x12345678. Required: GPIO[15:0]=0x5678 one cycle later and GPIO[31:16]=Z; OUT_SET 0x00000001 gives OUT=0x12345679; OUT_CLR 0x00000008 gives OUT=0x12345671.
- Read latency: write LED=0x3FF and read addr 0 in the same cycle. Required: odata returns the old value 0 next cycle, then 0x3FF on the following read; LEDR=0x3FF.
- Interrupts: set EDGE_SEL=0x1, IRQ_EN=0x3, then drive GPIO[0] 0→1 and GPIO[1] 1→0. Required: IRQ_STAT=0x3 at SYNC_STAGES+1 cycles after the change and irq=1 one cycle later; W1C 0x1 leaves 0x2 with irq still 1; W1C 0x2 drops irq the next cycle.
- Clear collision: issue a W1C to bit 0 on the same edge that a new bit-0 edge event occurs. Required: IRQ_STAT[0]=1.
- Undefined GPIO_IRQ_EN: write 0xFFFFFFFF to addresses 4–6 and toggle pins. Required: reads of 4–6 return 0, irq stays 0, and IN tracks the pins.
